// File: rtl/iq_player_pkg.sv
// ---------------------------------------------------------------------------
// iq_player_pkg
// Shared types and constants for the AXI-Stream IQ frame player.
//   player_state_t  : playback controller states.
//   MAX_OFDM_FRAME  : samples in one (ofdm_symbols+1)*(nfft+cp_len) frame,
//                     the largest frame the DAC chain replays today.
// ---------------------------------------------------------------------------
package iq_player_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      GAP   = 2'd2,
      DRAIN = 2'd3
   } player_state_t;

   localparam int MAX_OFDM_FRAME = 8704;

endpackage

// File: rtl/axis_iq_frame_player_if.sv
// ---------------------------------------------------------------------------
// axis_iq_frame_player_if
// AXI-Stream bundle carrying packed IQ beats.
//   tdata  : beat (I in the low SAMPLE_W bits, Q above it)
//   tvalid : beat valid          tready : sink ready
//   tlast  : last beat of frame  tkeep  : byte enables
// Modports: master (source side), slave (sink side).
// ---------------------------------------------------------------------------
interface axis_iq_frame_player_if #(
   parameter int DATA_W = 32
) ();

   logic [DATA_W-1:0]   tdata;
   logic                tvalid;
   logic                tready;
   logic                tlast;
   logic [DATA_W/8-1:0] tkeep;

   modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry output buffer that absorbs the one-cycle RAM read latency while
// the sink applies backpressure. tlast travels as a sideband bit.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   i_flush          : drop all held beats (tvalid low next cycle)
//   i_valid/i_data/i_last : beat arriving from the RAM read stage; the
//                      producer only sends when an entry is free
//   i_tready         : sink ready
//   o_tvalid/o_tdata/o_tlast : AXIS output, driven from registers only
//   o_count          : beats currently held (0..2), used for read credit
// ---------------------------------------------------------------------------
module axis_skid_buffer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   input  logic              i_tready,
   output logic              o_tvalid,
   output logic [DATA_W-1:0] o_tdata,
   output logic              o_tlast,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_data [2];
   logic [1:0]        r_last;
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic              w_pop;

   // tvalid depends only on the occupancy register, never on i_tready.
   assign o_tvalid = (r_count != 2'd0);
   assign w_pop    = o_tvalid & i_tready;
   assign o_tdata  = r_data[r_rptr];
   assign o_tlast  = r_last[r_rptr];
   assign o_count  = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_last    <= '0;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= 2'd0;
      end else if (i_flush) begin
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (i_valid) begin
            r_data[r_wptr] <= i_data;
            r_last[r_wptr] <= i_last;
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_count <= r_count + {1'b0, i_valid} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/axis_iq_frame_player.sv
// ---------------------------------------------------------------------------
// axis_iq_frame_player
// Replays a frame of packed IQ beats from on-chip RAM as an AXI-Stream,
// with run-time frame length, repeat count and inter-frame gap.
// Ports:
//   aclk, areset        : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : frame memory write port (accepted any time)
//   start, abort        : one-cycle control pulses
//   frame_len           : beats per frame (1..DEPTH), sampled on start
//   num_frames          : frames to play, 0 = continuous, sampled on start
//   gap_cycles          : idle cycles between frames, sampled on start
//   m_axis              : AXIS master (tdata/tvalid/tready/tlast/tkeep)
//   busy                : controller not idle
//   done                : one-cycle pulse on completion, abort or bad start
//   frame_cnt           : frames fully transferred since start (saturating)
// ---------------------------------------------------------------------------
module axis_iq_frame_player
   import iq_player_pkg::*;
#(
   parameter  int SAMPLE_W = 16,
   parameter  int NUM_CH   = 2,
   parameter  int DEPTH    = 16384,
   parameter  int GAP_W    = 16,
   localparam int DATA_W   = SAMPLE_W * NUM_CH,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDR_W:0]        frame_len,
   input  logic [15:0]            num_frames,
   input  logic [GAP_W-1:0]       gap_cycles,
   axis_iq_frame_player_if.master m_axis,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            frame_cnt
);

   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_vld;
   logic              r_rd_last;

   player_state_t     r_state;
   logic              r_busy;
   logic              r_done;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_len;
   logic [15:0]       r_nfr;
   logic [GAP_W-1:0]  r_gap;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic [15:0]       r_fr_iss;
   logic [15:0]       r_frame_cnt;

   logic              w_tvalid;
   logic [DATA_W-1:0] w_tdata;
   logic              w_tlast;
   logic [1:0]        w_sb_count;
   logic              w_xfer;
   logic              w_len_ok;
   logic              w_start_ok;
   logic              w_abort;
   logic [ADDR_W:0]   w_len_cur;
   logic [15:0]       w_nfr_cur;
   logic [GAP_W-1:0]  w_gap_cur;
   logic [15:0]       w_iss_cur;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_is_last;
   logic [2:0]        w_fill;
   logic [2:0]        w_fill_after;
   logic              w_can_issue;
   logic              w_rd_en;
   player_state_t     w_adv_state;
   logic [ADDR_W-1:0] w_adv_addr;
   logic [15:0]       w_adv_iss;

   assign w_xfer     = w_tvalid & m_axis.tready;
   assign w_len_ok   = (frame_len != '0) && (frame_len <= LEN_MAX);
   assign w_start_ok = (r_state == IDLE) && start && w_len_ok;
   assign w_abort    = (r_state != IDLE) && abort;

   // The start cycle itself issues the read of address 0 using the live
   // inputs, which is what makes the first beat valid two cycles later.
   assign w_len_cur  = w_start_ok ? frame_len  : r_len;
   assign w_nfr_cur  = w_start_ok ? num_frames : r_nfr;
   assign w_gap_cur  = w_start_ok ? gap_cycles : r_gap;
   assign w_iss_cur  = w_start_ok ? 16'd0      : r_fr_iss;
   assign w_rd_addr  = w_start_ok ? '0         : r_addr;
   assign w_is_last  = ({1'b0, w_rd_addr} == (w_len_cur - (ADDR_W+1)'(1)));

   // Read credit: beats held plus the one in the RAM stage, less the beat
   // leaving this cycle, must leave room for one more.
   assign w_fill       = {1'b0, w_sb_count} + {2'b00, r_rd_vld};
   assign w_fill_after = w_fill - {2'b00, w_xfer};
   assign w_can_issue  = (w_fill_after < 3'd2);
   assign w_rd_en      = !w_abort && w_can_issue && (w_start_ok || (r_state == PLAY));

   always_comb begin
      w_adv_state = PLAY;
      w_adv_addr  = w_rd_addr + ADDR_W'(1);
      w_adv_iss   = w_iss_cur;
      if (w_is_last) begin
         w_adv_iss  = w_iss_cur + 16'd1;
         w_adv_addr = '0;
         if ((w_nfr_cur != 16'd0) && (w_adv_iss == w_nfr_cur)) begin
            w_adv_state = DRAIN;
         end else if (w_gap_cur != '0) begin
            w_adv_state = GAP;
         end
      end
   end

   // Stage p0 -> p1: read-first frame RAM
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
      if (w_rd_en) begin
         r_rd_data <= r_mem[w_rd_addr];
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_addr      <= '0;
         r_len       <= '0;
         r_nfr       <= '0;
         r_gap       <= '0;
         r_gap_cnt   <= '0;
         r_fr_iss    <= '0;
         r_frame_cnt <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_last   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_rd_vld  <= w_rd_en;
         r_rd_last <= w_rd_en & w_is_last;
         if (w_xfer && w_tlast) begin
            r_frame_cnt <= sat_inc16(r_frame_cnt);
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (w_len_ok) begin
                     r_len       <= frame_len;
                     r_nfr       <= num_frames;
                     r_gap       <= gap_cycles;
                     r_frame_cnt <= '0;
                     r_busy      <= 1'b1;
                     r_state     <= w_adv_state;
                     r_addr      <= w_adv_addr;
                     r_fr_iss    <= w_adv_iss;
                     r_gap_cnt   <= w_gap_cur;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            PLAY: begin
               if (w_rd_en) begin
                  r_state   <= w_adv_state;
                  r_addr    <= w_adv_addr;
                  r_fr_iss  <= w_adv_iss;
                  r_gap_cnt <= w_gap_cur;
               end
            end
            GAP: begin
               // r_addr was already wrapped to 0 by the tlast read.
               if (r_gap_cnt <= GAP_W'(1)) begin
                  r_state <= PLAY;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            DRAIN: begin
               // Leave when the last held beat is leaving this cycle, so done
               // lands one cycle after the final transfer.
               if (w_fill_after == 3'd0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
         end
      end
   end

   // Stage p1 -> p2: output skid buffer
   axis_skid_buffer #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk      (aclk),
      .rst      (areset),
      .i_flush  (w_abort),
      .i_valid  (r_rd_vld),
      .i_data   (r_rd_data),
      .i_last   (r_rd_last),
      .i_tready (m_axis.tready),
      .o_tvalid (w_tvalid),
      .o_tdata  (w_tdata),
      .o_tlast  (w_tlast),
      .o_count  (w_sb_count)
   );

   assign m_axis.tdata  = w_tdata;
   assign m_axis.tvalid = w_tvalid;
   assign m_axis.tlast  = w_tlast;
   assign m_axis.tkeep  = '1;
   assign busy          = r_busy;
   assign done          = r_done;
   assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_axis_iq_frame_player.sv
module tb_axis_iq_frame_player;
   import iq_player_pkg::*;

   localparam int SAMPLE_W = 16;
   localparam int NUM_CH   = 2;
   localparam int DEPTH    = 16384;
   localparam int GAP_W    = 16;
   localparam int DATA_W   = SAMPLE_W * NUM_CH;
   localparam int ADDR_W   = $clog2(DEPTH);
   localparam int RAMP_LEN = MAX_OFDM_FRAME;

   logic                aclk = 1'b0;
   logic                areset = 1'b1;
   logic                wr_en = 1'b0;
   logic [ADDR_W-1:0]   wr_addr = '0;
   logic [DATA_W-1:0]   wr_data = '0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic [ADDR_W:0]     frame_len = '0;
   logic [15:0]         num_frames = '0;
   logic [GAP_W-1:0]    gap_cycles = '0;
   logic                busy;
   logic                done;
   logic [15:0]         frame_cnt;

   axis_iq_frame_player_if #(.DATA_W(DATA_W)) axis ();

   axis_iq_frame_player #(
      .SAMPLE_W (SAMPLE_W),
      .NUM_CH   (NUM_CH),
      .DEPTH    (DEPTH),
      .GAP_W    (GAP_W)
   ) dut (
      .aclk       (aclk),
      .areset     (areset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .abort      (abort),
      .frame_len  (frame_len),
      .num_frames (num_frames),
      .gap_cycles (gap_cycles),
      .m_axis     (axis),
      .busy       (busy),
      .done       (done),
      .frame_cnt  (frame_cnt)
   );

   always #5 aclk = ~aclk;

   int n_pass = 0;
   int n_checks = 0;

   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W:0]   got_q [$];
   logic [DATA_W:0]   exp_q [$];
   int                xfer_q [$];
   int                g_stab;
   int                g_done_cyc;
   int                g_first;
   int                g_busy_seen;
   int                g_busy_at_done;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic load_ramp();
      logic [15:0] iv;
      logic [15:0] qv;
      for (int n = 0; n < RAMP_LEN; n++) begin
         iv = n[15:0];
         qv = -iv;
         wr_en   = 1'b1;
         wr_addr = n[ADDR_W-1:0];
         wr_data = {qv, iv};
         ref_mem[n] = {qv, iv};
         tick();
      end
      wr_en = 1'b0;
   endtask

   // Pulses start in the current cycle (cycle 0); returns in cycle 1.
   task automatic do_start(input int len, input int nfr, input int gap);
      frame_len  = (ADDR_W+1)'(len);
      num_frames = 16'(nfr);
      gap_cycles = GAP_W'(gap);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Drives tready with the given percentage and records every transfer
   // until done is seen or the cycle budget runs out.
   task automatic collect(input int max_cyc, input int pct);
      logic            pv;
      logic            pr;
      logic [DATA_W:0] pd;
      got_q.delete();
      xfer_q.delete();
      g_stab = 0; g_done_cyc = -1; g_first = -1; g_busy_seen = 0; g_busy_at_done = -1;
      pv = 1'b0; pr = 1'b0; pd = '0;
      for (int c = 1; c <= max_cyc; c++) begin
         if (pv && !pr && (!axis.tvalid || ({axis.tlast, axis.tdata} != pd))) g_stab++;
         if (busy) g_busy_seen = 1;
         if (done) begin
            g_done_cyc = c;
            g_busy_at_done = int'(busy);
            break;
         end
         if (axis.tvalid && g_first < 0) g_first = c;
         axis.tready = ($urandom_range(0, 99) < pct);
         if (axis.tvalid && axis.tready) begin
            got_q.push_back({axis.tlast, axis.tdata});
            xfer_q.push_back(c);
         end
         pv = axis.tvalid; pr = axis.tready; pd = {axis.tlast, axis.tdata};
         tick();
      end
      axis.tready = 1'b0;
   endtask

   // Reference stream: nfr copies of memory[0..len-1], tlast on the final beat.
   function automatic void build_exp(input int len, input int nfr);
      exp_q.delete();
      for (int f = 0; f < nfr; f++)
         for (int a = 0; a < len; a++)
            exp_q.push_back({(a == len - 1), ref_mem[a]});
   endfunction

   function automatic int beat_errors();
      int e = 0;
      int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      if (got_q.size() != exp_q.size()) e++;
      for (int i = 0; i < n; i++)
         if (got_q[i] !== exp_q[i]) e++;
      return e;
   endfunction

   function automatic int last_xfer();
      return (xfer_q.size() > 0) ? xfer_q[xfer_q.size()-1] : -100;
   endfunction

   task automatic test_reset();
      axis.tready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      n_checks++; if (axis.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", axis.tvalid); else n_pass++;
      n_checks++; if (axis.tlast !== 1'b0) $display("FAIL rst_tlast: got %b expected 0", axis.tlast); else n_pass++;
      n_checks++; if (axis.tdata !== '0) $display("FAIL rst_tdata: got %h expected 0", axis.tdata); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); else n_pass++;
      n_checks++; if (axis.tkeep !== 4'hF) $display("FAIL tkeep: got %h expected f", axis.tkeep); else n_pass++;
      areset = 1'b0;
      tick();
   endtask

   task automatic test_single_frame();
      int tl = 0;
      do_start(RAMP_LEN, 1, 0);
      collect(RAMP_LEN + 50, 100);
      build_exp(RAMP_LEN, 1);
      foreach (got_q[i]) if (got_q[i][DATA_W]) tl++;
      n_checks++; if (g_first !== 2) $display("FAIL single_first_valid: got cycle %0d expected 2", g_first); else n_pass++;
      n_checks++; if (got_q.size() !== RAMP_LEN) $display("FAIL single_count: got %0d expected %0d", got_q.size(), RAMP_LEN); else n_pass++;
      n_checks++; if (beat_errors() !== 0) $display("FAIL single_beats: got %0d bad beats expected 0", beat_errors()); else n_pass++;
      n_checks++; if (tl !== 1) $display("FAIL single_tlast_count: got %0d expected 1", tl); else n_pass++;
      n_checks++; if (last_xfer() - g_first !== RAMP_LEN - 1) $display("FAIL single_throughput: got span %0d expected %0d", last_xfer() - g_first, RAMP_LEN - 1); else n_pass++;
      n_checks++; if (g_done_cyc !== last_xfer() + 1) $display("FAIL single_done_cycle: got %0d expected %0d", g_done_cyc, last_xfer() + 1); else n_pass++;
      n_checks++; if (g_busy_at_done !== 0) $display("FAIL single_busy_at_done: got %0d expected 0", g_busy_at_done); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd1) $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back_backpressure();
      int tl = 0;
      do_start(RAMP_LEN, 3, 0);
      collect(12 * RAMP_LEN, 50);
      build_exp(RAMP_LEN, 3);
      foreach (got_q[i]) if (got_q[i][DATA_W]) tl++;
      n_checks++; if (got_q.size() !== 3 * RAMP_LEN) $display("FAIL multi_count: got %0d expected %0d", got_q.size(), 3 * RAMP_LEN); else n_pass++;
      n_checks++; if (beat_errors() !== 0) $display("FAIL multi_beats: got %0d bad beats expected 0", beat_errors()); else n_pass++;
      n_checks++; if (tl !== 3) $display("FAIL multi_tlast_count: got %0d expected 3", tl); else n_pass++;
      n_checks++; if (g_stab !== 0) $display("FAIL multi_stability: got %0d violations expected 0", g_stab); else n_pass++;
      n_checks++; if (g_done_cyc !== last_xfer() + 1) $display("FAIL multi_done_cycle: got %0d expected %0d", g_done_cyc, last_xfer() + 1); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd3) $display("FAIL multi_frame_cnt: got %0d expected 3", frame_cnt); else n_pass++;
   endtask

   task automatic test_gap();
      int win;
      do_start(4, 2, 5);
      collect(100, 100);
      build_exp(4, 2);
      win = (xfer_q.size() >= 5) ? (xfer_q[4] - xfer_q[3] - 1) : -1;
      n_checks++; if (g_first !== 2) $display("FAIL gap_first_valid: got cycle %0d expected 2", g_first); else n_pass++;
      n_checks++; if (beat_errors() !== 0) $display("FAIL gap_beats: got %0d bad beats expected 0 (size %0d)", beat_errors(), got_q.size()); else n_pass++;
      n_checks++; if (win !== 5) $display("FAIL gap_window: got %0d idle cycles expected 5", win); else n_pass++;
      n_checks++; if (g_done_cyc !== last_xfer() + 1) $display("FAIL gap_done_cycle: got %0d expected %0d", g_done_cyc, last_xfer() + 1); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd2) $display("FAIL gap_frame_cnt: got %0d expected 2", frame_cnt); else n_pass++;
   endtask

   task automatic test_abort();
      int k = 0;
      int hit = 0;
      logic [DATA_W-1:0] seen = '0;
      do_start(200, 0, 0);
      axis.tready = 1'b1;
      for (int c = 1; c < 1000; c++) begin
         if (axis.tvalid) begin
            if (k == 300) begin
               seen = axis.tdata;
               abort = 1'b1;
               hit = 1;
               tick();
               abort = 1'b0;
               break;
            end
            k++;
         end
         tick();
      end
      n_checks++; if (hit !== 1) $display("FAIL abort_reached: got %0d expected 1", hit); else n_pass++;
      n_checks++; if (seen !== ref_mem[100]) $display("FAIL abort_beat_data: got %h expected %h", seen, ref_mem[100]); else n_pass++;
      n_checks++; if (axis.tvalid !== 1'b0) $display("FAIL abort_tvalid: got %b expected 0", axis.tvalid); else n_pass++;
      n_checks++; if (done !== 1'b1) $display("FAIL abort_done: got %b expected 1", done); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd1) $display("FAIL abort_frame_cnt: got %0d expected 1", frame_cnt); else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL abort_done_pulse: got %b expected 0", done); else n_pass++;
      axis.tready = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int k = 0;
      do_start(RAMP_LEN, 1, 0);
      axis.tready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (axis.tvalid && axis.tready) k++;
         if (k == 5) begin
            axis.tready = 1'b0;
            break;
         end
         tick();
      end
      tick();
      tick();
      n_checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== ref_mem[4]) $display("FAIL stall_beat: got v=%b d=%h expected v=1 d=%h", axis.tvalid, axis.tdata, ref_mem[4]); else n_pass++;
      areset = 1'b1;
      #1;
      n_checks++; if (axis.tvalid !== 1'b0) $display("FAIL arst_tvalid: got %b expected 0", axis.tvalid); else n_pass++;
      n_checks++; if (axis.tdata !== '0 || axis.tlast !== 1'b0) $display("FAIL arst_tdata_tlast: got %h/%b expected 0/0", axis.tdata, axis.tlast); else n_pass++;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL arst_busy_done: got %b/%b expected 0/0", busy, done); else n_pass++;
      n_checks++; if (frame_cnt !== 16'd0) $display("FAIL arst_frame_cnt: got %0d expected 0", frame_cnt); else n_pass++;
      #1;
      areset = 1'b0;
      tick();
      do_start(16, 1, 0);
      collect(60, 100);
      build_exp(16, 1);
      n_checks++; if (beat_errors() !== 0) $display("FAIL replay_beats: got %0d bad beats expected 0 (size %0d)", beat_errors(), got_q.size()); else n_pass++;
      n_checks++; if (g_first !== 2) $display("FAIL replay_first_valid: got cycle %0d expected 2", g_first); else n_pass++;
   endtask

   task automatic test_bad_len();
      do_start(0, 1, 0);
      collect(20, 100);
      n_checks++; if (g_done_cyc !== 1) $display("FAIL len0_done: got cycle %0d expected 1", g_done_cyc); else n_pass++;
      n_checks++; if (g_first !== -1) $display("FAIL len0_tvalid: got first valid %0d expected none", g_first); else n_pass++;
      n_checks++; if (g_busy_seen !== 0) $display("FAIL len0_busy: got %0d expected 0", g_busy_seen); else n_pass++;
      repeat (3) tick();
      do_start(DEPTH + 1, 1, 0);
      collect(20, 100);
      n_checks++; if (g_done_cyc !== 1) $display("FAIL lenbig_done: got cycle %0d expected 1", g_done_cyc); else n_pass++;
      n_checks++; if (g_first !== -1 || g_busy_seen !== 0) $display("FAIL lenbig_idle: got first=%0d busy=%0d expected -1/0", g_first, g_busy_seen); else n_pass++;
   endtask

   initial begin
      axis.tready = 1'b0;
      test_reset();
      load_ramp();
      test_single_frame();
      repeat (3) tick();
      test_back_to_back_backpressure();
      repeat (3) tick();
      test_gap();
      repeat (3) tick();
      test_abort();
      repeat (3) tick();
      test_reset_midframe();
      repeat (3) tick();
      test_bad_len();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axis_iq_frame_player.md
# axis_iq_frame_player

Parametrised AXI-Stream IQ frame source for the DAC chain. It replays a frame of packed IQ samples from an internal block RAM, for example (ofdm_symbols+1)·(nfft+cp_len) = 8704 samples. The playback length, repeat count and inter-frame gap are set at run time. Output honours full backpressure, and `tlast` marks the last sample of each frame. It sits between the processor-side sample loader and the DUC input, replacing file-driven stimulus with an on-chip, repeatable source.

## Interface
Parameters:
- `SAMPLE_W`, 16: bits per I or Q component.
- `NUM_CH`, 2: components per beat (I in the low slice, Q in the next); beat width `DATA_W = SAMPLE_W*NUM_CH`.
- `DEPTH`, 16384: frame memory depth in beats; `ADDR_W = $clog2(DEPTH)`.
- `GAP_W`, 16: width of the inter-frame gap counter.

Ports (one clock; reset is asynchronous and active-high):
- `aclk`  in  1  sole clock.
- `areset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  memory write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `start`  in  1  one-cycle pulse; begins playback when idle.
- `abort`  in  1  one-cycle pulse; stops playback.
- `frame_len`  in  ADDR_W+1  beats per frame, 1..DEPTH; sampled on `start`.
- `num_frames`  in  16  frames to play; 0 = continuous; sampled on `start`.
- `gap_cycles`  in  GAP_W  idle cycles between frames; sampled on `start`.
- `m_axis_tdata`  out  DATA_W  sample beat.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of a frame.
- `m_axis_tkeep`  out  DATA_W/8  tied all-ones.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on completion or abort.
- `frame_cnt`  out  16  frames fully transferred since `start`.

## Operation
- States: IDLE, PLAY, GAP, DRAIN.
- IDLE → PLAY on `start`:
  - latch `frame_len`, `num_frames` and `gap_cycles`;
  - read address ← 0;
  - `frame_cnt` ← 0.
- `start` is ignored outside IDLE.
- `frame_len` = 0 or > DEPTH: the start is rejected, the block stays in IDLE and pulses `done`.
- PLAY: issue one read per cycle while the skid buffer can accept a beat.
  - The beat read at address `frame_len-1` carries `tlast`.
  - After issuing that read:
    - if `num_frames` ≠ 0 and this is the final frame → DRAIN;
    - else if `gap_cycles` > 0 → GAP;
    - else the address wraps to 0 and the block stays in PLAY.
- GAP: count `gap_cycles` cycles with no reads issued, then go to PLAY at address 0. The counter starts after the `tlast` read is issued, not when the `tlast` beat is transferred.
- DRAIN: wait until the skid buffer is empty, then go to IDLE and pulse `done`.
- `frame_cnt` increments on each transfer where `tvalid & tready & tlast`. It saturates at 0xFFFF.
- `abort` in any state except IDLE:
  - stop reads immediately;
  - flush the skid buffer (`tvalid` drops the next cycle, even mid-frame without `tlast`);
  - go to IDLE and pulse `done`.
- `abort` and `start` in the same IDLE cycle: `start` wins.
- Memory writes are accepted in every state. A write to an address in the current frame during playback is legal; the beat read may be the old or new value (read-first RAM).

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0, `frame_cnt`=0, state IDLE. The skid buffer is empty on reset.
- Latency from `start` (cycle 0) to the first `m_axis_tvalid`: cycle 2 (1 cycle RAM read plus 1 register).
- With `tready` held high and `gap_cycles`=0, throughput is 1 beat per cycle, including across frame boundaries.
- AXIS rules:
  - Once asserted, `tvalid`, `tdata` and `tlast` hold stable until `tready` (except on abort).
  - No combinational path from `tready` to `tvalid`.
  - No beat is lost or duplicated under any `tready` pattern.
- `done` asserts 1 cycle after the last `tlast` transfer of the final frame.
- `busy` falls in the same cycle that `done` is high.
- Reset mid-playback returns every output to its reset value asynchronously. Memory contents are not cleared.

## Structure
- Package `iq_player_pkg`: `player_state_t` enum (IDLE, PLAY, GAP, DRAIN) and the `MAX_OFDM_FRAME = 8704` constant.
- Sub-module `axis_skid_buffer`: 2-entry, parametrised by `DATA_W` with `tlast` carried as a sideband bit. It absorbs RAM read latency under backpressure and provides a `flush` input used by abort.
- The frame memory is an inferred simple-dual-port, read-first RAM inside the top-level module.

## Test plan
- Load 8704 ramp beats (I=n, Q=−n); `frame_len`=8704, `num_frames`=1, `tready`=1.
  - Expect 8704 beats in order, first `tvalid` at cycle 2, `tlast` only on beat 8703.
  - `done` 1 cycle after the last beat; `frame_cnt`=1.
- Same load with `num_frames`=3, `gap_cycles`=0, and random 50 % `tready`.
  - Expect 26112 beats with no loss or duplication; `tlast` on every 8704th beat; `frame_cnt`=3.
- `frame_len`=4, `gap_cycles`=5, `num_frames`=2, `tready`=1.
  - Expect beats 0..3, then exactly 5 cycles with no reads issued (observable as a `tvalid`-low window), then beats 0..3.
- `num_frames`=0 (continuous), `abort` at beat 100 of frame 2.
  - Expect `tvalid`=0 on the next cycle, `done` pulse, `busy`=0, `frame_cnt`=1.
- Assert `areset` mid-frame with `tready`=0 and `tvalid`=1.
  - Expect all outputs at reset values immediately.
  - A new `start` then replays from beat 0 with memory contents intact.
- `start` with `frame_len`=0.
  - Expect no `tvalid`, a `done` pulse, and `busy` staying 0.
